ring_link_tx: RTL and testbench

//   Credit-based transmitter for one 20-bit hub link: clockwise ring, counter-clockwise ring, or up-to-super-hub.
//   It drives the data/valid pair toward a downstream receiver and consumes that receiver's credit-return pulses.
//   A local source injects flits through a ready/valid port. The block buffers them and launches one flit per

---
 rtl/ring_link_tx_if.sv | 21 ++
 rtl/ring_link_tx.sv | 104 ++++++++++
 tb/tb_ring_link_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_link_tx_if.sv
// Injection port of the ring link transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface ring_link_tx_if #(
   parameter int FLIT_W = 20
);
   logic [FLIT_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/ring_link_tx.sv
// Credit-based transmitter for one hub link.
// Buffers injected flits and launches one per downstream credit.
module ring_link_tx #(
   parameter int FLIT_W    = 20,
   parameter int CREDITS   = 4,
   parameter int CNT_W     = 3,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   ring_link_tx_if.slave     inj,
   output logic [FLIT_W-1:0] link_out,
   output logic              link_vo,
   input  logic              link_ci,
   output logic [CNT_W-1:0]  credit_cnt,
   output logic [1:0]        state,
   output logic              credit_err
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SEND  = 2'b01,
      STALL = 2'b10
   } state_t;

   state_t            st;
   logic [FLIT_W-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W:0]    count_nx;
   logic              full;
   logic              push;
   logic              pop;

   assign state = st;
   assign full  = (count == DEPTH);

   // Ready looks only at the pre-edge count, never at valid.
   assign inj.in_ready = rst & ~full;

   assign push = inj.in_valid & inj.in_ready;
   assign pop  = (count != '0) & (credit_cnt != '0);

   always_comb begin
      count_nx = count;
      count_nx = count_nx + {{PTR_W{1'b0}}, push};
      count_nx = count_nx - {{PTR_W{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= inj.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         link_out   <= '0;
         link_vo    <= 1'b0;
         credit_cnt <= CRED_MAX;
         credit_err <= 1'b0;
         st         <= IDLE;
      end else begin
         count <= count_nx;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            link_out <= mem[rd_ptr];
            link_vo  <= 1'b1;
            rd_ptr   <= rd_ptr + PTR_W'(1);
         end else begin
            link_out <= '0;
            link_vo  <= 1'b0;
         end
         // A credit and a launch on the same edge cancel out.
         unique case ({link_ci, pop})
            2'b10: begin
               if (credit_cnt == CRED_MAX) begin
                  credit_err <= 1'b1;
               end else begin
                  credit_cnt <= credit_cnt + CNT_W'(1);
               end
            end
            2'b01: credit_cnt <= credit_cnt - CNT_W'(1);
            default: credit_cnt <= credit_cnt;
         endcase
         if (pop) begin
            st <= SEND;
         end else if (credit_cnt == '0 && count_nx != '0) begin
            st <= STALL;
         end else begin
            st <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ring_link_tx.sv
// Bench for ring_link_tx: vector table plus scoreboard
// and hand-written reset and streaming sequences.
module tb_ring_link_tx;
   logic        clk;
   logic        rst;
   logic [19:0] link_out;
   logic        link_vo;
   logic        link_ci;
   logic [2:0]  credit_cnt;
   logic [1:0]  state;
   logic        credit_err;

   int n_cmp;
   int n_fail;
   logic [19:0] exp_q[$];

   typedef struct {
      logic        v;
      logic [19:0] d;
      logic        ci;
      logic        vo;
      logic [19:0] out;
      logic [2:0]  cnt;
      logic [1:0]  st;
      logic        rdy;
      logic        err;
   } vec_t;

   vec_t tbl[24];

   ring_link_tx_if #(.FLIT_W(20)) inj ();

   ring_link_tx #(
      .FLIT_W(20),
      .CREDITS(4),
      .CNT_W(3),
      .BUF_DEPTH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .inj(inj),
      .link_out(link_out),
      .link_vo(link_vo),
      .link_ci(link_ci),
      .credit_cnt(credit_cnt),
      .state(state),
      .credit_err(credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic v, input logic [19:0] d,
      input logic ci, input logic vo,
      input logic [19:0] o, input logic [2:0] c,
      input logic [1:0] s, input logic r,
      input logic e
   );
      vec_t t;
      t.v = v; t.d = d; t.ci = ci;
      t.vo = vo; t.out = o; t.cnt = c;
      t.st = s; t.rdy = r; t.err = e;
      return t;
   endfunction

   task automatic chk(
      input string name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step(
      input logic v,
      input logic [19:0] d,
      input logic ci
   );
      logic [19:0] ef;
      @(negedge clk);
      inj.in_valid = v;
      inj.in_data  = d;
      link_ci      = ci;
      #1;
      if (v && inj.in_ready) exp_q.push_back(d);
      @(posedge clk);
      #1;
      if (link_vo) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_extra: got %h want none", link_out);
         end else begin
            ef = exp_q.pop_front();
            chk("sb_flit", 32'(link_out), 32'(ef));
         end
      end else begin
         chk("idle_zero", 32'(link_out), 32'h0);
      end
   endtask

   initial begin
      int launches;
      n_cmp = 0;
      n_fail = 0;
      rst = 1'b1;
      link_ci = 1'b0;
      inj.in_valid = 1'b0;
      inj.in_data = '0;

      tbl[0]  = mk(1, 20'h40001, 0, 0, 20'h0,     4, 2'b00, 1, 0);
      tbl[1]  = mk(1, 20'h40002, 0, 1, 20'h40001, 3, 2'b01, 1, 0);
      tbl[2]  = mk(1, 20'h40003, 0, 1, 20'h40002, 2, 2'b01, 1, 0);
      tbl[3]  = mk(1, 20'h80004, 0, 1, 20'h40003, 1, 2'b01, 1, 0);
      tbl[4]  = mk(1, 20'hC0005, 0, 1, 20'h80004, 0, 2'b01, 1, 0);
      tbl[5]  = mk(1, 20'hC0006, 0, 0, 20'h0,     0, 2'b10, 0, 0);
      tbl[6]  = mk(0, 20'h0,     0, 0, 20'h0,     0, 2'b10, 0, 0);
      tbl[7]  = mk(0, 20'h0,     1, 0, 20'h0,     1, 2'b10, 0, 0);
      tbl[8]  = mk(0, 20'h0,     0, 1, 20'hC0005, 0, 2'b01, 1, 0);
      tbl[9]  = mk(0, 20'h0,     0, 0, 20'h0,     0, 2'b10, 1, 0);
      tbl[10] = mk(0, 20'h0,     1, 0, 20'h0,     1, 2'b10, 1, 0);
      tbl[11] = mk(0, 20'h0,     0, 1, 20'hC0006, 0, 2'b01, 1, 0);
      tbl[12] = mk(0, 20'h0,     0, 0, 20'h0,     0, 2'b00, 1, 0);
      tbl[13] = mk(0, 20'h0,     1, 0, 20'h0,     1, 2'b00, 1, 0);
      tbl[14] = mk(0, 20'h0,     1, 0, 20'h0,     2, 2'b00, 1, 0);
      tbl[15] = mk(1, 20'h40007, 0, 0, 20'h0,     2, 2'b00, 1, 0);
      tbl[16] = mk(0, 20'h0,     1, 1, 20'h40007, 2, 2'b01, 1, 0);
      tbl[17] = mk(0, 20'h0,     0, 0, 20'h0,     2, 2'b00, 1, 0);
      tbl[18] = mk(0, 20'h0,     1, 0, 20'h0,     3, 2'b00, 1, 0);
      tbl[19] = mk(0, 20'h0,     1, 0, 20'h0,     4, 2'b00, 1, 0);
      tbl[20] = mk(0, 20'h0,     1, 0, 20'h0,     4, 2'b00, 1, 1);
      tbl[21] = mk(1, 20'hC0008, 0, 0, 20'h0,     4, 2'b00, 1, 1);
      tbl[22] = mk(0, 20'h0,     0, 1, 20'hC0008, 3, 2'b01, 1, 1);
      tbl[23] = mk(0, 20'h0,     1, 0, 20'h0,     4, 2'b00, 1, 1);

      // Asynchronous reset asserted mid-cycle, no clock edge.
      #3;
      rst = 1'b0;
      #1;
      chk("rst_vo", 32'(link_vo), 32'h0);
      chk("rst_out", 32'(link_out), 32'h0);
      chk("rst_cnt", 32'(credit_cnt), 32'h4);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_err", 32'(credit_err), 32'h0);
      chk("rst_ready", 32'(inj.in_ready), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_ready", 32'(inj.in_ready), 32'h1);

      for (int i = 0; i < 24; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].ci);
         chk($sformatf("vo[%0d]", i),
             32'(link_vo), 32'(tbl[i].vo));
         chk($sformatf("out[%0d]", i),
             32'(link_out), 32'(tbl[i].out));
         chk($sformatf("cnt[%0d]", i),
             32'(credit_cnt), 32'(tbl[i].cnt));
         chk($sformatf("st[%0d]", i),
             32'(state), 32'(tbl[i].st));
         chk($sformatf("rdy[%0d]", i),
             32'(inj.in_ready), 32'(tbl[i].rdy));
         chk($sformatf("err[%0d]", i),
             32'(credit_err), 32'(tbl[i].err));
      end

      // Streaming: valid held high, a credit every cycle.
      launches = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 20'hC0100 + 20'(i), 1'b1);
         if (link_vo) launches++;
         chk("cnt_le_4", 32'(credit_cnt <= 3'd4), 32'h1);
      end
      chk("throughput", 32'(launches), 32'd19);
      chk("err_sticky", 32'(credit_err), 32'h1);

      // Reset mid-stream drops the link at once.
      #2;
      rst = 1'b0;
      #1;
      chk("mid_vo", 32'(link_vo), 32'h0);
      chk("mid_out", 32'(link_out), 32'h0);
      chk("mid_cnt", 32'(credit_cnt), 32'h4);
      chk("mid_state", 32'(state), 32'h0);
      chk("mid_err", 32'(credit_err), 32'h0);
      chk("mid_ready", 32'(inj.in_ready), 32'h0);
      exp_q.delete();
      inj.in_valid = 1'b0;
      link_ci = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 20'h0, 1'b0);
         chk("flushed_vo", 32'(link_vo), 32'h0);
         chk("flushed_cnt", 32'(credit_cnt), 32'h4);
         chk("flushed_rdy", 32'(inj.in_ready), 32'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end
endmodule
